// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register-table sequencer.
package cam_cfg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_IDLE,
      ST_DELAY,
      ST_NEXT,
      ST_DONE
   } cfg_state_t;

   // Table word that ends the run
   localparam logic [15:0] CFG_END     = 16'hFFFF;
   // Table word that inserts a fixed pause
   localparam logic [15:0] CFG_DELAY   = 16'hFFF0;
   // 8-bit SCCB write address of the camera (7-bit 0x21)
   localparam logic [7:0]  CAMERA_ADDR = 8'h42;

endpackage

// File: rtl/cam_config_rom.sv
// Synchronous register-table ROM, one clock read latency.
// TABLE packs entry i at bits [16*i +: 16]; unused entries default to the end marker.
module cam_config_rom #(
   parameter int                     AW    = 8,
   parameter logic [(2**AW)*16-1:0]  TABLE = '1
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output logic [15:0]   data
);

   // Registered read
   always_ff @(posedge clk) begin
      data <= TABLE[{addr, 4'b0000} +: 16];
   end

endmodule

// File: rtl/cam_config_sequencer.sv
// Walks a {reg_addr, reg_value} table ROM and issues one SCCB write per entry.
// Optional per-transaction watchdog enabled by defining CFG_WATCHDOG_EN.
module cam_config_sequencer
   import cam_cfg_pkg::*;
#(
   parameter int CLK_FREQ     = 25000000,
   parameter int ROM_AW       = 8,
   parameter int DELAY_CYCLES = 250000,
   parameter int WDOG_CYCLES  = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   input  logic              sccb_ready,
   output logic              sccb_start,
   output logic [7:0]        sccb_address,
   output logic [7:0]        sccb_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int TW = $clog2(DELAY_CYCLES + 1);

   // Reject nonsensical timing parameters at elaboration
   if (CLK_FREQ < 1 || DELAY_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_check
      $error("cam_config_sequencer: CLK_FREQ, DELAY_CYCLES, WDOG_CYCLES must be positive");
   end

   cfg_state_t        state, state_n;
   logic [ROM_AW-1:0] addr_n;
   logic [7:0]        reg_a_n, reg_d_n;
   logic              start_n, busy_n, done_n;
   logic [TW-1:0]     timer, timer_n;

`ifdef CFG_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog, wdog_n;
   logic          error_n;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      addr_n  = rom_addr;
      reg_a_n = sccb_address;
      reg_d_n = sccb_data;
      start_n = 1'b0;
      done_n  = 1'b0;
      busy_n  = busy;
      timer_n = timer;
`ifdef CFG_WATCHDOG_EN
      wdog_n  = wdog;
      error_n = error;
`endif
      case (state)
         ST_IDLE: begin
            if (cfg_start) begin
               addr_n  = '0;
               busy_n  = 1'b1;
`ifdef CFG_WATCHDOG_EN
               error_n = 1'b0;
`endif
               state_n = ST_FETCH;
            end
         end
         ST_FETCH: state_n = ST_DECODE;
         ST_DECODE: begin
            if (rom_data == CFG_END) begin
               state_n = ST_DONE;
            end else if (rom_data == CFG_DELAY) begin
               timer_n = TW'(DELAY_CYCLES - 1);
               state_n = ST_DELAY;
            end else begin
               reg_a_n = rom_data[15:8];
               reg_d_n = rom_data[7:0];
`ifdef CFG_WATCHDOG_EN
               wdog_n  = '0;
`endif
               state_n = ST_ISSUE;
            end
         end
         // Never start while the engine may still be finishing an older write
         ST_ISSUE: begin
            if (sccb_ready) begin
               start_n = 1'b1;
               state_n = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: if (!sccb_ready) state_n = ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (sccb_ready) state_n = ST_NEXT;
         ST_DELAY: begin
            if (timer == '0) state_n = ST_NEXT;
            else             timer_n = timer - TW'(1);
         end
         // Last address always terminates; the address never wraps
         ST_NEXT: begin
            if (rom_addr == '1) begin
               state_n = ST_DONE;
            end else begin
               addr_n  = rom_addr + ROM_AW'(1);
               state_n = ST_FETCH;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
`ifdef CFG_WATCHDOG_EN
      if (state inside {ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_IDLE}) begin
         if (wdog == WW'(WDOG_CYCLES - 1)) begin
            error_n = 1'b1;
            start_n = 1'b0;
            state_n = ST_DONE;
         end else begin
            wdog_n = wdog + WW'(1);
         end
      end
`endif
      // done and the fall of busy land in the same cycle
      if (state_n == ST_DONE && state != ST_DONE) begin
         done_n = 1'b1;
         busy_n = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         rom_addr     <= '0;
         sccb_address <= '0;
         sccb_data    <= '0;
         sccb_start   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timer        <= '0;
      end else begin
         state        <= state_n;
         rom_addr     <= addr_n;
         sccb_address <= reg_a_n;
         sccb_data    <= reg_d_n;
         sccb_start   <= start_n;
         busy         <= busy_n;
         done         <= done_n;
         timer        <= timer_n;
      end
   end

`ifdef CFG_WATCHDOG_EN
   // Watchdog counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog  <= '0;
         error <= 1'b0;
      end else begin
         wdog  <= wdog_n;
         error <= error_n;
      end
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Self-checking bench for cam_config_sequencer: table-driven runs plus
// hand-written reset / restart / watchdog sequences.
module tb_cam_config_sequencer;

   localparam int AW     = 2;
   localparam int DLY    = 100;
   localparam int WD     = 50;
   localparam int BUSY_T = 40;

   logic          clk = 1'b0;
   logic          rst, cfg_start;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_data;
   logic          sccb_ready = 1'b1;
   logic          sccb_start, busy, done, error;
   logic [7:0]    sccb_address, sccb_data;

   logic [AW-1:0] rom_chk_addr;
   logic [15:0]   rom_chk_data;

   cam_config_sequencer #(
      .CLK_FREQ(25000000), .ROM_AW(AW), .DELAY_CYCLES(DLY), .WDOG_CYCLES(WD)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .rom_addr(rom_addr),
      .rom_data(rom_data), .sccb_ready(sccb_ready), .sccb_start(sccb_start),
      .sccb_address(sccb_address), .sccb_data(sccb_data), .busy(busy),
      .done(done), .error(error)
   );

   cam_config_rom #(.AW(AW), .TABLE(64'hFFFF_1101_FFF0_1280)) u_rom (
      .clk(clk), .addr(rom_chk_addr), .data(rom_chk_data)
   );

   always #5 clk = ~clk;

   // Writable table model with one clock read latency
   logic [15:0] tbl [4];
   always @(posedge clk) rom_data <= tbl[rom_addr];

   // SCCB engine model: drops ready the clock after start, busy ~BUSY_T clocks
   int          eng_cnt = 0;
   bit          eng_hang = 1'b0;
   logic [15:0] wr_log [$];
   always @(posedge clk) begin
      if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
      else if (!sccb_ready) begin
         if (!eng_hang) sccb_ready <= 1'b1;
      end else if (sccb_start === 1'b1) begin
         sccb_ready <= 1'b0;
         eng_cnt    <= BUSY_T - 1;
         wr_log.push_back({sccb_address, sccb_data});
      end
   end

   // Event monitors, sampled mid-cycle
   int            cyc = 0, done_cnt = 0, viol = 0, wrap = 0, db_bad = 0, err_seen = 0;
   int            done_cyc = 0;
   logic          err_at_done = 1'b0;
   int            start_q [$], rise_q [$];
   logic          prev_ready = 1'b1, prev_busy = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   always @(negedge clk) begin
      cyc++;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc    = cyc;
         err_at_done = error;
         if (busy !== 1'b0 || prev_busy !== 1'b1) db_bad++;
      end
      if (sccb_start === 1'b1) begin
         start_q.push_back(cyc);
         if (!sccb_ready) viol++;
      end
      if (sccb_ready && !prev_ready) rise_q.push_back(cyc);
      if (busy === 1'b1 && prev_busy === 1'b1 && prev_addr != 0 && rom_addr == 0) wrap++;
      if (error === 1'b1) err_seen++;
      prev_ready = sccb_ready;
      prev_busy  = busy;
      prev_addr  = rom_addr;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_done(input int d0, output bit to);
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt != d0) begin
            to = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run(output logic bsy, output bit to);
      int d0;
      d0        = done_cnt;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      bsy       = busy;
      wait_done(d0, to);
   endtask

   typedef struct {
      string           nm;
      logic [3:0][15:0] t;
      int              nw;
      logic [3:0][15:0] w;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [15:0] a, b, c, d,
                               input int nw, input logic [15:0] w0, w1, w2, w3);
      vec_t v;
      v.nm = nm;
      v.t[0] = a;  v.t[1] = b;  v.t[2] = c;  v.t[3] = d;
      v.nw = nw;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs [6];
      logic [15:0] rom_exp [4];
      logic [15:0] got;
      logic        bsy;
      bit          to;
      int          d0, wrap0, db0, v0, gap, sz;

      rst = 1'b1; cfg_start = 1'b0; rom_chk_addr = '0;
      for (int i = 0; i < 4; i++) tbl[i] = 16'hFFFF;
      repeat (3) @(posedge clk); #1;
      chk("reset_outputs", 32'({rom_addr, sccb_start, sccb_address, sccb_data, busy, done, error}), 0);
      rst = 1'b0;

      // ROM sub-module reads
      rom_exp[0] = 16'h1280; rom_exp[1] = 16'hFFF0; rom_exp[2] = 16'h1101; rom_exp[3] = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         rom_chk_addr = AW'(i);
         @(posedge clk); #1;
         chk($sformatf("rom_read_%0d", i), 32'(rom_chk_data), 32'(rom_exp[i]));
      end

      vecs[0] = mk("basic",   16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 2,
                   16'h1280, 16'h1101, 16'h0, 16'h0);
      vecs[1] = mk("delay",   16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF, 2,
                   16'h1280, 16'h1101, 16'h0, 16'h0);
      vecs[2] = mk("exhaust", 16'hA001, 16'hA102, 16'hA203, 16'hA304, 4,
                   16'hA001, 16'hA102, 16'hA203, 16'hA304);
      vecs[3] = mk("empty",   16'hFFFF, 16'h1280, 16'h1101, 16'hFFFF, 0,
                   16'h0, 16'h0, 16'h0, 16'h0);
      vecs[4] = mk("dly_1st", 16'hFFF0, 16'h3355, 16'hFFFF, 16'hFFFF, 1,
                   16'h3355, 16'h0, 16'h0, 16'h0);
      vecs[5] = mk("near_mk", 16'hFFF1, 16'hFFFE, 16'hFFFF, 16'hFFFF, 2,
                   16'hFFF1, 16'hFFFE, 16'h0, 16'h0);

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 4; i++) tbl[i] = vecs[v].t[i];
         wr_log.delete(); start_q.delete(); rise_q.delete();
         d0 = done_cnt; wrap0 = wrap; db0 = db_bad;
         run(bsy, to);
         chk({vecs[v].nm, "_busy"}, 32'(bsy), 1);
         chk({vecs[v].nm, "_timeout"}, 32'(to), 0);
         repeat (5) @(posedge clk); #1;
         chk({vecs[v].nm, "_nwrites"}, wr_log.size(), vecs[v].nw);
         for (int i = 0; i < vecs[v].nw; i++) begin
            got = (i < wr_log.size()) ? wr_log[i] : 16'hxxxx;
            chk($sformatf("%s_write%0d", vecs[v].nm, i), 32'(got), 32'(vecs[v].w[i]));
         end
         chk({vecs[v].nm, "_done_once"}, done_cnt - d0, 1);
         chk({vecs[v].nm, "_done_busy_edge"}, db_bad - db0, 0);
         chk({vecs[v].nm, "_addr_no_wrap"}, wrap - wrap0, 0);
         if (v == 1) begin
            gap = (start_q.size() >= 2 && rise_q.size() >= 1) ? start_q[1] - rise_q[0] : -1;
            chk("delay_gap_min", 32'(gap >= DLY), 1);
            chk("delay_gap_max", 32'(gap >= 0 && gap <= DLY + 10), 1);
         end
      end

      // cfg_start pulsed mid-table is ignored
      tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'hFFFF; tbl[3] = 16'hFFFF;
      wr_log.delete(); d0 = done_cnt;
      cfg_start = 1'b1; @(posedge clk); #1; cfg_start = 1'b0;
      repeat (60) @(posedge clk); #1;
      cfg_start = 1'b1; @(posedge clk); #1; cfg_start = 1'b0;
      wait_done(d0, to);
      repeat (60) @(posedge clk); #1;
      chk("restart_ignored_timeout", 32'(to), 0);
      chk("restart_ignored_nwrites", wr_log.size(), 2);
      chk("restart_ignored_done", done_cnt - d0, 1);

      // rst and cfg_start together: rst wins
      sz = start_q.size();
      rst = 1'b1; cfg_start = 1'b1; @(posedge clk); #1;
      rst = 1'b0; cfg_start = 1'b0; @(posedge clk); #1;
      chk("rst_wins_busy", 32'(busy), 0);
      repeat (10) @(posedge clk); #1;
      chk("rst_wins_no_start", start_q.size() - sz, 0);

      // Reset while waiting for the engine, then restart
      sz = start_q.size(); d0 = done_cnt; v0 = viol;
      cfg_start = 1'b1; @(posedge clk); #1; cfg_start = 1'b0;
      for (int i = 0; i < 100 && start_q.size() == sz; i++) begin
         @(posedge clk); #1;
      end
      chk("rst_mid_first_start", 32'(start_q.size() > sz), 1);
      repeat (20) @(posedge clk); #1;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      chk("rst_mid_busy", 32'({busy, sccb_start}), 0);
      wr_log.delete();
      run(bsy, to);
      chk("rst_mid_restart_timeout", 32'(to), 0);
      repeat (5) @(posedge clk); #1;
      chk("rst_mid_nwrites", wr_log.size(), 2);
      chk("rst_mid_no_overlap", viol - v0, 0);
      chk("rst_mid_done_once", done_cnt - d0, 1);

`ifdef CFG_WATCHDOG_EN
      // Engine accepts and never returns ready
      start_q.delete(); wr_log.delete();
      eng_hang = 1'b1;
      run(bsy, to);
      chk("wdog_timeout", 32'(to), 0);
      chk("wdog_error", 32'(err_at_done), 1);
      chk("wdog_latency", 32'((start_q.size() > 0) ? done_cyc - start_q[0] : -1), WD - 1);
      repeat (3) @(posedge clk); #1;
      chk("wdog_sticky", 32'(error), 1);
      eng_hang = 1'b0;
      repeat (3) @(posedge clk); #1;
      wr_log.delete();
      run(bsy, to);
      chk("wdog_rerun_timeout", 32'(to), 0);
      chk("wdog_error_cleared", 32'(err_at_done), 0);
      chk("wdog_rerun_nwrites", wr_log.size(), 2);
`else
      chk("error_tied_low", err_seen, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_config_sequencer.md
Name: cam_config_sequencer

Overview:
- Walks a synchronous register-table ROM of {reg_addr, reg_value} words and issues one write per entry to the camera SCCB write engine (start/address/data/ready).
- Supports inline delay entries and an end marker.
- Sits between the top-level camera bring-up logic and the SCCB engine; pulses done once the whole table has been written.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz; documentation and derived-delay use only.
- ROM_AW, 8, ROM address width; the table holds at most 2^ROM_AW entries.
- DELAY_CYCLES, 250000, clocks waited on a delay entry (10 ms at 25 MHz).
- WDOG_CYCLES, 1000000, watchdog limit per SCCB transaction (used only with CFG_WATCHDOG_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle request to run the table from entry 0.
- rom_addr  out  ROM_AW  ROM read address.
- rom_data  in  16  ROM word {reg_addr[15:8], reg_value[7:0]}; valid 1 clk after rom_addr.
- sccb_ready  in  1  SCCB engine idle.
- sccb_start  out  1  one-cycle write request to the SCCB engine.
- sccb_address  out  8  register address; held stable during a transaction.
- sccb_data  out  8  register value; held stable during a transaction.
- busy  out  1  high from acceptance of cfg_start until done.
- done  out  1  one-cycle pulse on table completion.
- error  out  1  sticky watchdog flag; constant 0 without CFG_WATCHDOG_EN.

Behaviour:
- Reset values: rom_addr=0, sccb_start=0, sccb_address=0, sccb_data=0, busy=0, done=0, error=0, timer=0, state=IDLE.
- IDLE:
  - cfg_start=1 -> rom_addr<=0, busy<=1, error<=0, go to FETCH.
  - cfg_start while busy is ignored.
- FETCH: one wait cycle for the 1-clk ROM latency -> DECODE.
- DECODE (rom_data is valid here):
  - 16'hFFFF: end marker -> DONE.
  - 16'hFFF0: delay entry -> timer<=DELAY_CYCLES-1, go to DELAY.
  - Any other word: latch sccb_address=rom_data[15:8] and sccb_data=rom_data[7:0] -> ISSUE.
- ISSUE: wait until sccb_ready=1, then drive sccb_start=1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY: wait for sccb_ready=0, i.e. the engine has accepted the request; it drops ready on the clock after start -> WAIT_IDLE.
- WAIT_IDLE: wait for sccb_ready=1 -> NEXT.
- DELAY: decrement timer; when timer==0 -> NEXT. Exactly DELAY_CYCLES clocks are spent in DELAY.
- NEXT:
  - rom_addr==2^ROM_AW-1: table exhausted without a marker -> DONE.
  - Otherwise rom_addr<=rom_addr+1 -> FETCH.
- DONE: done=1 for one cycle, busy<=0 -> IDLE. A later cfg_start reruns the table from entry 0.
- Address arithmetic: rom_addr never wraps; the last address always terminates the run.
- Reset mid-operation: the sequencer returns to IDLE immediately. The SCCB engine has no reset, so an in-flight transaction may complete. ISSUE always waits for sccb_ready=1 first, so a restarted run never overlaps that transaction.
- Simultaneous rst and cfg_start: rst wins.
- sccb_ready low at reset: the sequencer stalls in ISSUE, with no start pulse, until ready rises.

Optional Feature:
- Macro: CFG_WATCHDOG_EN.
- With the macro:
  - A counter clears on entry to ISSUE and increments in ISSUE, WAIT_BUSY and WAIT_IDLE.
  - When the count reaches WDOG_CYCLES: error<=1 (sticky until the next accepted cfg_start), then DONE; done still pulses.
- Without the macro: no counter; error tied to 0; the sequencer waits indefinitely.

Decomposition:
- Shared package cam_cfg_pkg holds:
  - state enum encoding;
  - CFG_END=16'hFFFF;
  - CFG_DELAY=16'hFFF0;
  - CAMERA_ADDR=8'h42.
- Natural sub-module: cam_config_rom, the synchronous table ROM with 1-clk latency that is instantiated beside the sequencer. The sequencer itself stays a single FSM.

Test Plan:
- Table {0x1280, 0x1101, 0xFFFF}, SCCB engine model with 40-clk busy time -> exactly 2 sccb_start pulses carrying (0x12,0x80) then (0x11,0x01); done pulses once; busy falls in the same cycle.
- Table {0x1280, 0xFFF0, 0x1101, 0xFFFF} with DELAY_CYCLES=100 -> gap between ready returning after the first write and the second sccb_start ≥ 100 clks.
- ROM_AW=2 filled with 4 non-marker words -> 4 writes, then done; rom_addr never returns to 0 during the run.
- cfg_start pulsed again mid-table -> ignored; exactly one write per entry.
- rst asserted while WAIT_IDLE with sccb_ready=0 for 20 more clks, then cfg_start -> first sccb_start only after ready=1.
- CFG_WATCHDOG_EN, WDOG_CYCLES=50, sccb_ready held 0 after start -> error=1 and done pulse 50 clks after entering ISSUE.
